// File: rtl/mips_pkg.sv
// Shared definitions for the instruction loader: state encoding, word geometry
// and the end-of-program marker.
package mips_pkg;

  localparam int LEN            = 32;
  localparam int BYTES_PER_WORD = LEN / 8;
  localparam logic [LEN-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_RECEIVE = 3'd1,
    LD_WRITE   = 3'd2,
    LD_DONE    = 3'd3,
    LD_ERROR   = 3'd4
  } loader_state_t;

  // A new load session may only begin from a resting state.
  function automatic logic start_allowed(input loader_state_t st);
    return (st == LD_IDLE) || (st == LD_DONE) || (st == LD_ERROR);
  endfunction

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Packs received bytes MSB-first into an instruction word; word_ready flags the
// strobe that completes a word, with the completed word presented the same cycle.
module byte_packer #(
  parameter int len = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic [7:0]     in_rx_data,
  input  logic           in_rx_done,
  output logic [len-1:0] word,
  output logic           word_ready
);

  localparam int NBYTES = len / 8;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  // Only the lower len-8 bits need storing; the oldest byte shifts out on completion.
  logic [len-9:0]   shift_q;
  logic [CNT_W-1:0] cnt_q;

  assign word       = {shift_q, in_rx_data};
  assign word_ready = in_rx_done && (cnt_q == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (in_rx_done) begin
      shift_q <= word[len-9:0];
      cnt_q   <= word_ready ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from the UART byte stream into instruction memory, holding
// the CPU in reset until the HALT word has been written.
//
// state   | meaning
// IDLE    | after reset, waiting for in_start
// RECEIVE | collecting bytes of the next word
// WRITE   | single-cycle memory write of the packed word
// DONE    | HALT written, CPU released
// ERROR   | memory filled before HALT, CPU kept in reset
module instruction_loader #(
  parameter int              len       = 32,
  parameter int              ADDR_W    = 10,
  parameter logic [len-1:0]  HALT_WORD = mips_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_start,
  input  logic [7:0]        in_rx_data,
  input  logic              in_rx_done,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [len-1:0]    out_wr_data,
  output logic              out_cpu_hold,
  output logic              out_done,
  output logic              out_overflow
);

  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  loader_state_t  state_q;
  logic           pk_clear;
  logic           pk_rx_done;
  logic [len-1:0] pk_word;
  logic           pk_word_ready;

  // Bytes are taken in WRITE too, so a strobe landing on the write cycle is not lost.
  assign pk_rx_done = in_rx_done && ((state_q == LD_RECEIVE) || (state_q == LD_WRITE));
  assign pk_clear   = in_start && start_allowed(state_q);

  byte_packer #(
    .len(len)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .in_rx_data (in_rx_data),
    .in_rx_done (pk_rx_done),
    .word       (pk_word),
    .word_ready (pk_word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LD_IDLE;
      out_wr_en    <= 1'b0;
      out_wr_addr  <= '0;
      out_wr_data  <= '0;
      out_cpu_hold <= 1'b0;
      out_done     <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      out_wr_en <= 1'b0;
      case (state_q)
        LD_IDLE, LD_DONE, LD_ERROR: begin
          if (pk_clear) begin
            state_q      <= LD_RECEIVE;
            out_wr_addr  <= '0;
            out_cpu_hold <= 1'b1;
            out_done     <= 1'b0;
            out_overflow <= 1'b0;
          end
        end
        LD_RECEIVE: begin
          if (pk_word_ready) begin
            state_q     <= LD_WRITE;
            out_wr_en   <= 1'b1;
            out_wr_data <= pk_word;
          end
        end
        LD_WRITE: begin
          if (out_wr_data == HALT_WORD) begin
            state_q      <= LD_DONE;
            out_done     <= 1'b1;
            out_cpu_hold <= 1'b0;
          end else if (out_wr_addr == LAST_ADDR) begin
            // Last slot holds a real instruction; there is nowhere left for HALT.
            state_q      <= LD_ERROR;
            out_overflow <= 1'b1;
          end else begin
            state_q     <= LD_RECEIVE;
            out_wr_addr <= out_wr_addr + 1'b1;
          end
        end
        default: begin
          state_q <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Program loader on the writer side of instruction memory; the fetch/decode path is the reader.
- Takes bytes from the UART receiver, packs every 4 into a 32-bit instruction word and writes each word to instruction memory at consecutive word addresses.
- Holds the CPU in reset while loading. Stops after writing the HALT word.

Parameters:
- len, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_W, 10, instruction memory word-address width (depth 2^ADDR_W words).
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is also written to memory.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_start  input  1  one-cycle pulse that begins a load session.
- in_rx_data  input  8  received UART byte.
- in_rx_done  input  1  one-cycle strobe; in_rx_data is valid this cycle.
- out_wr_en  output  1  instruction memory write enable, one cycle per word.
- out_wr_addr  output  ADDR_W  word address of the write.
- out_wr_data  output  len  packed instruction word.
- out_cpu_hold  output  1  holds the CPU pipeline in reset while high.
- out_done  output  1  level; program loaded, HALT written.
- out_overflow  output  1  level; memory full before HALT.

Behaviour:
- Reset: the FSM is IDLE.
  - out_wr_en=0, out_wr_addr=0, out_wr_data=0.
  - out_cpu_hold=0, out_done=0, out_overflow=0.
  - Byte count=0, word count=0, shift register=0.
  - A reset in any state discards any partial word. It takes priority over every other input.
- States: IDLE, RECEIVE, WRITE, DONE, ERROR. Encoding is binary.
- IDLE:
  - in_start -> RECEIVE. Clears byte count, word address, out_done and out_overflow. Sets out_cpu_hold=1.
  - in_rx_done is ignored.
- RECEIVE:
  - Each in_rx_done shifts the byte in from the LSB end: word <= {word[len-9:0], byte]. The first byte received ends up in bits [31:24] (big-endian).
  - The byte count increments.
  - On the 4th byte the next state is WRITE, the byte count returns to 0 and the full word is latched into out_wr_data.
- WRITE (exactly one cycle):
  - out_wr_en=1, out_wr_addr = current word address.
  - If out_wr_data==HALT_WORD -> DONE.
  - Else if the address == 2^ADDR_W-1 -> ERROR; the last slot is written, but no room is left for HALT.
  - Else the address increments and the FSM returns to RECEIVE.
  - An in_rx_done in the WRITE cycle is accepted as byte 1 of the next word. No byte is ever dropped.
- Latency: out_wr_en is asserted in the cycle after the cycle holding the 4th in_rx_done.
- DONE:
  - out_done=1, out_cpu_hold=0. out_wr_addr holds the HALT address.
  - in_rx_done is ignored.
  - in_start restarts loading at address 0 (-> RECEIVE, hold=1, done=0).
- ERROR:
  - out_overflow=1, out_cpu_hold stays 1 (the CPU must not run a truncated program).
  - Only in_start or reset leaves ERROR. in_start behaves as in DONE.
- in_start while in RECEIVE or WRITE is ignored.
- out_wr_en is 0 in every state except WRITE.
- Address arithmetic is unsigned ADDR_W-bit and never wraps silently; wrap is the ERROR condition above.
- All outputs are registered.

Decomposition:
- Shared package mips_pkg:
  - Loader state enum (IDLE, RECEIVE, WRITE, DONE, ERROR).
  - HALT_WORD constant.
  - BYTES_PER_WORD = len/8.
- One sub-module: byte_packer, holding the shift register and a 2-bit byte counter.
  - Inputs: clk, reset, clear, in_rx_data, in_rx_done.
  - Outputs: word and a word_ready pulse.
- The FSM and address counter stay in instruction_loader.

Test Plan:
- Reset then start; send bytes 20 01 00 05 then FF FF FF FF -> two write pulses: addr 0 data 32'h20010005, then addr 1 data 32'hFFFFFFFF. Then out_done=1 and out_cpu_hold=0 one cycle after the second write.
- Back-to-back strobes: in_rx_done high on 8 consecutive cycles (bytes 0x01..0x08), with the 5th strobe landing in the WRITE cycle -> words 32'h01020304 at addr 0 and 32'h05060708 at addr 1; no byte lost.
- Overflow with ADDR_W=2: 4 non-HALT words (32'h00000001..4) -> writes to addr 0..3, then out_overflow=1 and out_cpu_hold=1. A 5th word produces no write.
- Reset mid-word: start, send AA BB, assert reset, then start and send 11 22 33 44 -> single write addr 0 data 32'h11223344. AA/BB do not appear.
- Ignored inputs:
  - rx bytes while IDLE, then start + 4 bytes -> only the post-start bytes are packed.
  - in_start pulsed during RECEIVE -> address is not reset; the load continues.
- Reload after DONE: complete a program, then pulse in_start -> out_done=0, out_cpu_hold=1, next write at addr 0.
